// File: rtl/game_clock_counter.sv
// rtl/game_clock_counter.sv - elapsed mm:ss game clock fed by a 1 ms pulse, BCD outputs
// Counts ms pulses into seconds and a saturating 99:59 BCD value, with start/pause/clear control.
module game_clock_counter #(
  parameter int MS_PER_SEC = 1000,
  parameter int MS_CNT_W   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic       one_ms_pulse,
  output logic       timer_enable,
  output logic       running,
  output logic       sec_tick,
  output logic       maxed,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUNNING,
    S_PAUSED,
    S_MAXED
  } state_t;

  localparam logic [MS_CNT_W-1:0] MS_LAST = MS_CNT_W'(MS_PER_SEC - 1);
  localparam logic [MS_CNT_W-1:0] MS_ONE  = MS_CNT_W'(1);

  state_t              state_q, state_d;
  logic [MS_CNT_W-1:0] ms_cnt_q, ms_cnt_d;
  logic [3:0]          min_tens_q, min_tens_d;
  logic [3:0]          min_ones_q, min_ones_d;
  logic [3:0]          sec_tens_q, sec_tens_d;
  logic [3:0]          sec_ones_q, sec_ones_d;
  logic                sec_tick_q, sec_tick_d;
  logic                maxed_q, maxed_d;
  logic                timer_enable_q, timer_enable_d;
  logic                running_q, running_d;

  logic [3:0] inc_min_tens, inc_min_ones, inc_sec_tens, inc_sec_ones;
  logic       count_pulse;
  logic       wrap;
  logic       reach_max;

  // One-second BCD increment; never applied at 99:59 because that state stops counting.
  always_comb begin
    inc_min_tens = min_tens_q;
    inc_min_ones = min_ones_q;
    inc_sec_tens = sec_tens_q;
    inc_sec_ones = sec_ones_q;
    if (sec_ones_q == 4'd9) begin
      inc_sec_ones = 4'd0;
      if (sec_tens_q == 4'd5) begin
        inc_sec_tens = 4'd0;
        if (min_ones_q == 4'd9) begin
          inc_min_ones = 4'd0;
          inc_min_tens = min_tens_q + 4'd1;
        end else begin
          inc_min_ones = min_ones_q + 4'd1;
        end
      end else begin
        inc_sec_tens = sec_tens_q + 4'd1;
      end
    end else begin
      inc_sec_ones = sec_ones_q + 4'd1;
    end
  end

  assign count_pulse = (state_q == S_RUNNING) && one_ms_pulse && !clear;
  assign wrap        = count_pulse && (ms_cnt_q == MS_LAST);
  assign reach_max   = (inc_min_tens == 4'd9) && (inc_min_ones == 4'd9) &&
                       (inc_sec_tens == 4'd5) && (inc_sec_ones == 4'd9);

  always_comb begin
    state_d    = state_q;
    ms_cnt_d   = ms_cnt_q;
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    sec_tick_d = 1'b0;
    if (clear) begin
      state_d    = S_IDLE;
      ms_cnt_d   = '0;
      min_tens_d = 4'd0;
      min_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      sec_ones_d = 4'd0;
    end else begin
      case (state_q)
        S_IDLE, S_PAUSED: if (start && !pause) state_d = S_RUNNING;
        S_RUNNING:        if (pause) state_d = S_PAUSED;
        default:          state_d = state_q;
      endcase
      // Saturation overrides a simultaneous pause.
      if (wrap) begin
        ms_cnt_d   = '0;
        min_tens_d = inc_min_tens;
        min_ones_d = inc_min_ones;
        sec_tens_d = inc_sec_tens;
        sec_ones_d = inc_sec_ones;
        sec_tick_d = 1'b1;
        if (reach_max) state_d = S_MAXED;
      end else if (count_pulse) begin
        ms_cnt_d = ms_cnt_q + MS_ONE;
      end
    end
    timer_enable_d = (state_d == S_RUNNING);
    running_d      = (state_d == S_RUNNING);
    maxed_d        = (state_d == S_MAXED);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      ms_cnt_q       <= '0;
      min_tens_q     <= 4'd0;
      min_ones_q     <= 4'd0;
      sec_tens_q     <= 4'd0;
      sec_ones_q     <= 4'd0;
      sec_tick_q     <= 1'b0;
      maxed_q        <= 1'b0;
      timer_enable_q <= 1'b0;
      running_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      ms_cnt_q       <= ms_cnt_d;
      min_tens_q     <= min_tens_d;
      min_ones_q     <= min_ones_d;
      sec_tens_q     <= sec_tens_d;
      sec_ones_q     <= sec_ones_d;
      sec_tick_q     <= sec_tick_d;
      maxed_q        <= maxed_d;
      timer_enable_q <= timer_enable_d;
      running_q      <= running_d;
    end
  end

  assign timer_enable = timer_enable_q;
  assign running      = running_q;
  assign sec_tick     = sec_tick_q;
  assign maxed        = maxed_q;
  assign min_tens     = min_tens_q;
  assign min_ones     = min_ones_q;
  assign sec_tens     = sec_tens_q;
  assign sec_ones     = sec_ones_q;

endmodule

// File: tb/tb_game_clock_counter.sv
// tb/tb_game_clock_counter.sv - self-checking bench for game_clock_counter
// A reference model pushes expected mm:ss values on each wrapping pulse; a monitor pops them on sec_tick.
module tb_game_clock_counter;
  localparam int MS_PER_SEC = 4;
  localparam int ST_IDLE = 0, ST_RUN = 1, ST_PAUSED = 2, ST_MAX = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, pause = 1'b0, clear = 1'b0, one_ms_pulse = 1'b0;
  logic       timer_enable, running, sec_tick, maxed;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [15:0] dut_digits;
  logic [19:0] all_out;

  game_clock_counter #(.MS_PER_SEC(MS_PER_SEC), .MS_CNT_W(2)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .clear(clear),
    .one_ms_pulse(one_ms_pulse), .timer_enable(timer_enable), .running(running),
    .sec_tick(sec_tick), .maxed(maxed), .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones)
  );

  assign dut_digits = {min_tens, min_ones, sec_tens, sec_ones};
  assign all_out    = {dut_digits, sec_tick, maxed, timer_enable, running};

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [15:0] digits;
  } exp_t;
  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;
  int m_ms = 0, m_sec = 0, m_st = ST_IDLE;

  function automatic logic [15:0] bcd_of(input int s);
    int mn, sc;
    mn = s / 60;
    sc = s % 60;
    return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10)};
  endfunction

  // Scoreboard monitor: every sec_tick must match the oldest expected second, on time.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
        checks++; errors++;
        $display("FAIL sec_tick_missing: sec_tick=%0b at cycle %0d, required 1 at cycle %0d", sec_tick, cyc, sb_q[0].due);
        void'(sb_q.pop_front());
      end
      if (sec_tick) begin
        checks++;
        if (sb_q.size() == 0 || sb_q[0].due != cyc) begin
          errors++;
          $display("FAIL sec_tick_unexpected: sec_tick=1 at cycle %0d, required 0", cyc);
        end else begin
          e = sb_q.pop_front();
          if (dut_digits !== e.digits) begin
            errors++;
            $display("FAIL tick_digits: got %h required %h", dut_digits, e.digits);
          end
        end
      end
    end
  end

  // Drive one cycle of control inputs (called at a negedge, returns at the next one) and advance the model.
  task automatic step(input logic s, input logic p, input logic c, input logic pl);
    exp_t e;
    logic cnt;
    start = s; pause = p; clear = c; one_ms_pulse = pl;
    cnt = (m_st == ST_RUN) && pl;
    if (c) begin
      m_st = ST_IDLE; m_ms = 0; m_sec = 0;
    end else begin
      case (m_st)
        ST_IDLE, ST_PAUSED: if (s && !p) m_st = ST_RUN;
        ST_RUN:             if (p) m_st = ST_PAUSED;
        default: ;
      endcase
      if (cnt) begin
        if (m_ms == MS_PER_SEC - 1) begin
          m_ms = 0;
          m_sec++;
          e.due = cyc + 1;
          e.digits = bcd_of(m_sec);
          sb_q.push_back(e);
          if (m_sec == 99 * 60 + 59) m_st = ST_MAX;
        end else begin
          m_ms++;
        end
      end
    end
    @(negedge clk);
    start = 1'b0; pause = 1'b0; clear = 1'b0; one_ms_pulse = 1'b0;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (all_out !== 20'h0) begin
      errors++; $display("FAIL reset_outputs: got %h required %h", all_out, 20'h0);
    end
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (all_out !== 20'h0) begin
      errors++; $display("FAIL idle_ignores_pulse: got %h required %h", all_out, 20'h0);
    end
  endtask

  task automatic test_first_second;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({timer_enable, running} !== 2'b11) begin
      errors++; $display("FAIL start_running: got %b required 11", {timer_enable, running});
    end
    pulses(4);
    checks++;
    if ({dut_digits, sec_tick, maxed, timer_enable, running} !== {16'h0001, 4'b1011}) begin
      errors++; $display("FAIL first_second: got %h required %h", all_out, {16'h0001, 4'b1011});
    end
  endtask

  task automatic test_carries;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (all_out !== 20'h0) begin
      errors++; $display("FAIL clear_outputs: got %h required %h", all_out, 20'h0);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 240; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      if (m_ms == 0 && m_sec == 10) begin
        checks++;
        if (dut_digits !== 16'h0010) begin
          errors++; $display("FAIL carry_00_10: got %h required %h", dut_digits, 16'h0010);
        end
      end
    end
    checks++;
    if (dut_digits !== 16'h0100) begin
      errors++; $display("FAIL carry_01_00: got %h required %h", dut_digits, 16'h0100);
    end
  endtask

  task automatic test_pause_resume;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    pulses(22);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({timer_enable, running} !== 2'b00) begin
      errors++; $display("FAIL pause_enable: got %b required 00", {timer_enable, running});
    end
    pulses(10);
    checks++;
    if ({dut_digits, timer_enable} !== {16'h0005, 1'b0}) begin
      errors++; $display("FAIL paused_hold: got %h/%b required 0005/0", dut_digits, timer_enable);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    pulses(1);
    checks++;
    if ({dut_digits, sec_tick} !== {16'h0005, 1'b0}) begin
      errors++; $display("FAIL resume_partial: got %h/%b required 0005/0", dut_digits, sec_tick);
    end
    pulses(1);
    checks++;
    if ({dut_digits, sec_tick} !== {16'h0006, 1'b1}) begin
      errors++; $display("FAIL resume_second: got %h/%b required 0006/1", dut_digits, sec_tick);
    end
  endtask

  task automatic test_same_cycle;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    pulses(3);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({dut_digits, sec_tick, running} !== {16'h0001, 2'b10}) begin
      errors++; $display("FAIL pause_with_pulse: got %h/%b%b required 0001/10", dut_digits, sec_tick, running);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    pulses(3);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (all_out !== 20'h0) begin
      errors++; $display("FAIL clear_with_pulse: got %h required %h", all_out, 20'h0);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    pulses(3);
    checks++;
    if ({dut_digits, sec_tick} !== {16'h0000, 1'b0}) begin
      errors++; $display("FAIL subcount_cleared: got %h/%b required 0000/0", dut_digits, sec_tick);
    end
    pulses(1);
    checks++;
    if ({dut_digits, sec_tick} !== {16'h0001, 1'b1}) begin
      errors++; $display("FAIL after_clear_second: got %h/%b required 0001/1", dut_digits, sec_tick);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({timer_enable, running} !== 2'b00) begin
      errors++; $display("FAIL start_pause_together: got %b required 00", {timer_enable, running});
    end
  endtask

  task automatic test_saturation;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    pulses((99 * 60 + 58) * MS_PER_SEC);
    checks++;
    if ({dut_digits, maxed} !== {16'h9958, 1'b0}) begin
      errors++; $display("FAIL preload_9958: got %h/%b required 9958/0", dut_digits, maxed);
    end
    pulses(4);
    checks++;
    if (all_out !== {16'h9959, 4'b1100}) begin
      errors++; $display("FAIL reach_9959: got %h required %h", all_out, {16'h9959, 4'b1100});
    end
    pulses(8);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (all_out !== {16'h9959, 4'b0100}) begin
      errors++; $display("FAIL maxed_hold: got %h required %h", all_out, {16'h9959, 4'b0100});
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (all_out !== 20'h0) begin
      errors++; $display("FAIL maxed_clear: got %h required %h", all_out, 20'h0);
    end
  endtask

  task automatic test_reset_mid;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    pulses((3 * 60 + 27) * MS_PER_SEC + 1);
    checks++;
    if (dut_digits !== 16'h0327) begin
      errors++; $display("FAIL reach_0327: got %h required %h", dut_digits, 16'h0327);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (all_out !== 20'h0) begin
      errors++; $display("FAIL async_reset: got %h required %h", all_out, 20'h0);
    end
    m_st = ST_IDLE; m_ms = 0; m_sec = 0;
    sb_q.delete();
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (all_out !== {16'h0000, 4'b0011}) begin
      errors++; $display("FAIL restart_no_pulses: got %h required %h", all_out, {16'h0000, 4'b0011});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    test_reset;
    test_first_second;
    test_carries;
    test_pause_resume;
    test_same_cycle;
    test_saturation;
    test_reset_mid;
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
